pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Fetch-control FSM that sequences the 16-bit program counter of the CPU.
//  Reads PC, fetches the instruction from program memory, hands it to the decoder,
//  then pulses the PC control lanes: +1, signed 8-bit branch displacement, or absolute jump.
//  Sits between program_counter, program memory and the decode stage.
// PARAMETERS
//  MEM_TIMEOUT  15  max WAIT_MEM cycles without MemReady before FetchError (1..255)
// PORTS
//  Clock          in   1   system clock; all state changes on rising edge
//  Reset          in   1   asynchronous, active-low reset
//  PC             in   16  current program counter value
//  MemAddr        out  16  program memory address (registered)
//  MemRead        out  1   memory read request; held until MemReady
//  MemReady       in   1   memory data valid this cycle
//  MemData        in   16  instruction word from memory
//  Instr          out  16  captured instruction to decoder
//  InstrValid     out  1   Instr valid, held until accepted
//  InstrAccept    in   1   decoder takes Instr this cycle
//  Stall          in   1   pipeline stall; blocks acceptance in ISSUE
//  BranchTaken    in   1   sampled with accept: apply BranchDisp
//  BranchDisp     in   8   signed (two's-complement) branch displacement
//  JumpTaken      in   1   sampled with accept: load JumpTarget
//  JumpTarget     in   16  absolute jump address
//  PcIncrement    out  1   to PC increment lane (one-cycle pulse)
//  PcIn           out  8   displacement to PC In lane
//  PcImm          out  16  to PC ImmIn lane
//  PcWriteEnable  out  1   to PC WriteEnable lane (one-cycle pulse)
//  Halt           in   1   halt request
//  Halted         out  1   FSM in HALT state
//  FetchError     out  1   sticky memory timeout flag
// BEHAVIOUR
//  Reset low: state IDLE; every output 0 immediately (async), timeout counter 0.
//  States: IDLE, FETCH, WAIT_MEM, ISSUE, UPDATE, HALT.
//  IDLE: Halt=1 -> HALT, else -> FETCH.
//  FETCH (1 cycle): MemAddr<=PC, MemRead<=1, counter<=0 -> WAIT_MEM.
//  WAIT_MEM: MemRead=1, MemAddr stable. On MemReady: Instr<=MemData, InstrValid<=1,
//   MemRead<=0 -> ISSUE. Otherwise counter+1. Counter==MEM_TIMEOUT without MemReady:
//   MemRead<=0, FetchError<=1 -> HALT.
//  ISSUE: InstrValid=1, Instr stable. InstrAccept ignored while Stall=1. On
//   InstrAccept & ~Stall: latch Branch/Jump inputs, InstrValid<=0 -> UPDATE.
//  UPDATE (exactly 1 cycle, exactly one lane pulsed):
//   JumpTaken: PcWriteEnable=1, PcImm=JumpTarget (jump wins over branch).
//   else BranchTaken: PcIncrement=1, PcIn=BranchDisp.
//   else PcIncrement=1, PcIn=8'h01.
//   Next: Halt=1 -> HALT, else FETCH. PC updates on the edge leaving UPDATE,
//   so FETCH sees the new PC. Instruction period = 4 cycles + memory wait.
//  PcIn/PcImm return to 0 outside UPDATE. PcIncrement and PcWriteEnable are never both high.
//  Arithmetic: sign extension and 16-bit wrap are done by the PC block, not here.
//   BranchDisp 8'h00 is legal (self-loop). 8'h80 = -128.
//  Halt in FETCH/WAIT_MEM/ISSUE is deferred; the in-flight instruction completes.
//  HALT: Halted=1, MemRead=0. Exit to FETCH when Halt=0 and FetchError=0.
//   FetchError is cleared only by Reset.
//  Reset mid-fetch: MemRead drops immediately; the fetch is abandoned and
//   restarts from IDLE at the PC then present.
// TESTING
//  1 Reset release, PC=0, MemReady 2 cycles after MemRead, MemData=16'h1234, accept, no
//    branch -> MemAddr 0000, Instr 1234, one PcIncrement pulse with PcIn 01, next MemAddr 0001.
//  2 PC=0010, BranchTaken, BranchDisp=8'hFE -> PcIncrement with PcIn FE; next MemAddr 000E.
//  3 JumpTaken and BranchTaken with JumpTarget=BEEF -> PcWriteEnable, PcImm BEEF,
//    PcIncrement=0; next MemAddr BEEF.
//  4 MemReady never asserts -> after MEM_TIMEOUT (15) cycles FetchError=1, Halted=1,
//    MemRead=0; toggling Halt does not clear it; Reset pulse clears it.
//  5 Stall=1 with InstrAccept=1 for 3 cycles -> InstrValid held, no PC pulse;
//    Stall=0 -> accepted, UPDATE on the following cycle.
//  6 Reset low during WAIT_MEM -> MemRead, InstrValid and PC lanes are 0 in the same
//    cycle; after release the FSM refetches from IDLE.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_fetch_sequencer : fetch-control FSM driving program memory and PC lanes |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module pc_fetch_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] PC,
  output logic [15:0] MemAddr,
  output logic        MemRead,
  input  logic        MemReady,
  input  logic [15:0] MemData,
  output logic [15:0] Instr,
  output logic        InstrValid,
  input  logic        InstrAccept,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [7:0]  BranchDisp,
  input  logic        JumpTaken,
  input  logic [15:0] JumpTarget,
  output logic        PcIncrement,
  output logic [7:0]  PcIn,
  output logic [15:0] PcImm,
  output logic        PcWriteEnable,
  input  logic        Halt,
  output logic        Halted,
  output logic        FetchError
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_MEM = 3'd2,
    S_ISSUE    = 3'd3,
    S_UPDATE   = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  localparam logic [7:0] c_TIMEOUT = 8'(MEM_TIMEOUT);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_count;
  logic [15:0] r_mem_addr;
  logic        r_mem_read;
  logic [15:0] r_instr;
  logic        r_instr_valid;
  logic        r_fetch_error;
  logic        r_jump;
  logic        r_branch;
  logic [7:0]  r_disp;
  logic [15:0] r_target;
  logic        w_accept;
  logic        w_timeout;

  assign w_accept  = InstrAccept && !Stall;
  // Counter holds the number of WAIT_MEM cycles already spent without data.
  assign w_timeout = (r_count == c_TIMEOUT) && !MemReady;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    PcIncrement   = 1'b0;
    PcWriteEnable = 1'b0;
    PcIn          = 8'h00;
    PcImm         = 16'h0000;
    case (r_state)
      S_IDLE:     w_next = Halt ? S_HALT : S_FETCH;
      S_FETCH:    w_next = S_WAIT_MEM;
      S_WAIT_MEM: begin
        if (MemReady) begin
          w_next = S_ISSUE;
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end
      S_ISSUE:    if (w_accept) w_next = S_UPDATE;
      S_UPDATE: begin
        w_next = Halt ? S_HALT : S_FETCH;
        if (r_jump) begin
          PcWriteEnable = 1'b1;
          PcImm         = r_target;
        end else begin
          PcIncrement = 1'b1;
          PcIn        = r_branch ? r_disp : 8'h01;
        end
      end
      S_HALT:     if (!Halt && !r_fetch_error) w_next = S_FETCH;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count       <= 8'd0;
      r_mem_addr    <= 16'h0000;
      r_mem_read    <= 1'b0;
      r_instr       <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_fetch_error <= 1'b0;
      r_jump        <= 1'b0;
      r_branch      <= 1'b0;
      r_disp        <= 8'h00;
      r_target      <= 16'h0000;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_mem_addr <= PC;
          r_mem_read <= 1'b1;
          r_count    <= 8'd0;
        end
        S_WAIT_MEM: begin
          if (MemReady) begin
            r_instr       <= MemData;
            r_instr_valid <= 1'b1;
            r_mem_read    <= 1'b0;
          end else if (w_timeout) begin
            r_mem_read    <= 1'b0;
            r_fetch_error <= 1'b1;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_jump        <= JumpTaken;
            r_branch      <= BranchTaken;
            r_disp        <= BranchDisp;
            r_target      <= JumpTarget;
            r_instr_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign MemAddr    = r_mem_addr;
  assign MemRead    = r_mem_read;
  assign Instr      = r_instr;
  assign InstrValid = r_instr_valid;
  assign FetchError = r_fetch_error;
  assign Halted     = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// Testbench for pc_fetch_sequencer: scoreboard of fetch addresses, instructions
// and PC-lane pulses against a transaction-level PC model.
module tb_pc_fetch_sequencer;
  localparam int MEM_TIMEOUT = 15;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] PC;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic        MemReady = 1'b0;
  logic [15:0] MemData = 16'h0;
  logic [15:0] Instr;
  logic        InstrValid;
  logic        InstrAccept = 1'b0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [7:0]  BranchDisp = 8'h0;
  logic        JumpTaken = 1'b0;
  logic [15:0] JumpTarget = 16'h0;
  logic        PcIncrement;
  logic [7:0]  PcIn;
  logic [15:0] PcImm;
  logic        PcWriteEnable;
  logic        Halt = 1'b0;
  logic        Halted;
  logic        FetchError;

  pc_fetch_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .PC(PC),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemReady(MemReady), .MemData(MemData),
    .Instr(Instr), .InstrValid(InstrValid), .InstrAccept(InstrAccept), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchDisp(BranchDisp),
    .JumpTaken(JumpTaken), .JumpTarget(JumpTarget),
    .PcIncrement(PcIncrement), .PcIn(PcIn), .PcImm(PcImm), .PcWriteEnable(PcWriteEnable),
    .Halt(Halt), .Halted(Halted), .FetchError(FetchError)
  );

  always #5 Clock = ~Clock;

  // Program-counter block the sequencer drives; it is not reset by Reset.
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0;
  always @(posedge Clock) begin
    if (pc_load) PC <= pc_load_val;
    else if (PcWriteEnable) PC <= PcImm;
    else if (PcIncrement) PC <= PC + {{8{PcIn[7]}}, PcIn};
  end

  typedef struct {
    bit          jmp;
    logic [7:0]  in;
    logic [15:0] imm;
  } upd_t;

  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_instr_q[$];
  upd_t        exp_upd_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] model_pc = 16'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: address of the next fetch after one instruction.
  function automatic logic [15:0] next_pc(input logic [15:0] pc, input bit br,
                                          input logic [7:0] d, input bit j,
                                          input logic [15:0] t);
    int step;
    if (j) return t;
    step = br ? int'($signed(d)) : 1;
    return 16'(int'(pc) + step);
  endfunction

  // Monitor: pops expectations whenever the DUT presents a fetch, instruction or PC pulse.
  bit prev_rd = 0;
  bit prev_vld = 0;
  always @(negedge Clock) begin
    if (!Reset) begin
      prev_rd  = 0;
      prev_vld = 0;
    end else begin
      if (MemRead && !prev_rd) begin
        if (exp_addr_q.size() == 0) fail("unexpected_fetch");
        else chk("fetch_addr", MemAddr, exp_addr_q.pop_front());
      end
      if (InstrValid && !prev_vld) begin
        if (exp_instr_q.size() == 0) fail("unexpected_instr");
        else chk("instr", Instr, exp_instr_q.pop_front());
      end
      if (PcIncrement && PcWriteEnable) begin
        fail("both_lanes_high");
      end else if (PcIncrement || PcWriteEnable) begin
        if (exp_upd_q.size() == 0) begin
          fail("unexpected_pc_pulse");
        end else begin
          upd_t u;
          u = exp_upd_q.pop_front();
          if (u.jmp) chk("jump_lane", {PcWriteEnable, PcIncrement, PcImm}, {1'b1, 1'b0, u.imm});
          else chk("incr_lane", {PcWriteEnable, PcIncrement, PcIn}, {1'b0, 1'b1, u.in});
        end
      end else begin
        chk("idle_lanes", {PcIn, PcImm}, 24'h0);
      end
      prev_rd  = MemRead;
      prev_vld = InstrValid;
    end
  end

  task automatic wait_read(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      if (MemRead) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail("memread_wait_expired");
  endtask

  task automatic do_reset(input bit halt_on_release);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("reset_outputs", {MemAddr, MemRead, Instr, InstrValid, PcIncrement, PcIn, PcImm,
                          PcWriteEnable, Halted, FetchError}, 64'h0);
    MemReady = 0; InstrAccept = 0; Stall = 0; BranchTaken = 0; JumpTaken = 0;
    Halt = halt_on_release;
    @(negedge Clock);
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_upd_q.delete();
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  // One full instruction: fetch with lat empty WAIT_MEM cycles, stalls, then accept.
  task automatic do_instr(input int lat, input logic [15:0] data, input int stalls,
                          input bit br, input logic [7:0] disp, input bit jmp,
                          input logic [15:0] tgt, input bit halt_mid);
    bit ok;
    upd_t u;
    exp_addr_q.push_back(model_pc);
    wait_read(ok);
    if (!ok) return;
    if (halt_mid) Halt = 1'b1;
    repeat (lat) begin
      MemData = 16'($urandom);
      @(negedge Clock);
    end
    MemReady = 1'b1;
    MemData  = data;
    exp_instr_q.push_back(data);
    @(negedge Clock);
    MemReady = 1'b0;
    MemData  = 16'($urandom);
    chk("issue_valid", InstrValid, 1'b1);
    for (int i = 0; i < stalls; i++) begin
      InstrAccept = 1'b1; Stall = 1'b1;
      BranchTaken = 1'($urandom); JumpTaken = 1'($urandom);
      BranchDisp = 8'($urandom); JumpTarget = 16'($urandom);
      @(negedge Clock);
      chk("stall_hold", {InstrValid, PcIncrement, PcWriteEnable}, 3'b100);
    end
    InstrAccept = 1'b1; Stall = 1'b0;
    BranchTaken = br; BranchDisp = disp; JumpTaken = jmp; JumpTarget = tgt;
    u.jmp = jmp;
    u.in  = br ? disp : 8'h01;
    u.imm = tgt;
    exp_upd_q.push_back(u);
    model_pc = next_pc(model_pc, br, disp, jmp, tgt);
    @(negedge Clock);
    InstrAccept = 1'b0;
    BranchTaken = 1'($urandom); JumpTaken = 1'($urandom);
    BranchDisp = 8'($urandom); JumpTarget = 16'($urandom);
    chk("update_pulse", {InstrValid, PcIncrement | PcWriteEnable}, 2'b01);
    if (halt_mid) begin
      repeat (2) begin
        @(negedge Clock);
        chk("halted_after_update", {Halted, MemRead}, 2'b10);
      end
      Halt = 1'b0;
    end
  endtask

  task automatic abort_fetch(input bit in_issue);
    bit ok;
    exp_addr_q.push_back(model_pc);
    wait_read(ok);
    if (!ok) return;
    if (in_issue) begin
      MemReady = 1'b1;
      MemData  = 16'($urandom);
      exp_instr_q.push_back(MemData);
      @(negedge Clock);
      MemReady = 1'b0;
      chk("pre_abort_valid", InstrValid, 1'b1);
    end else begin
      @(negedge Clock);
      chk("pre_abort_read", MemRead, 1'b1);
    end
    do_reset(1'b0);
  endtask

  task automatic timeout_test();
    bit ok;
    int n;
    exp_addr_q.push_back(model_pc);
    wait_read(ok);
    if (!ok) return;
    n = 0;
    do begin
      n++;
      @(negedge Clock);
    end while (MemRead && n < 100);
    // Error fires in the cycle after MEM_TIMEOUT empty cycles have been counted.
    chk("timeout_cycles", n, MEM_TIMEOUT + 1);
    chk("timeout_state", {FetchError, Halted, MemRead}, 3'b110);
    Halt = 1'b1;
    repeat (3) @(negedge Clock);
    Halt = 1'b0;
    repeat (3) @(negedge Clock);
    chk("error_sticky", {FetchError, Halted, MemRead}, 3'b110);
    do_reset(1'b0);
  endtask

  initial begin
    pc_load = 1'b1;
    pc_load_val = 16'h0000;
    repeat (2) @(negedge Clock);
    pc_load = 1'b0;
    chk("reset_outputs", {MemAddr, MemRead, Instr, InstrValid, PcIncrement, PcIn, PcImm,
                          PcWriteEnable, Halted, FetchError}, 64'h0);
    Reset = 1'b1;
    model_pc = 16'h0000;

    do_instr(2, 16'h1234, 0, 0, 8'h00, 0, 16'h0000, 0);   // 0000 -> 0001
    do_instr(1, 16'h0BAD, 0, 1, 8'h33, 1, 16'h0010, 0);   // 0001 -> jump 0010
    do_instr(0, 16'h2222, 0, 1, 8'hFE, 0, 16'h0000, 0);   // 0010 -> 000E
    do_instr(3, 16'h3333, 0, 1, 8'h05, 1, 16'hBEEF, 0);   // 000E -> BEEF
    do_instr(MEM_TIMEOUT, 16'h4444, 3, 1, 8'h80, 0, 16'h0, 0); // BEEF -> BE6F
    do_instr(1, 16'h5555, 1, 1, 8'h00, 0, 16'h0, 0);      // self-loop
    do_instr(0, 16'h6666, 0, 0, 8'h00, 1, 16'hFFFF, 0);
    do_instr(2, 16'h7777, 0, 0, 8'h00, 0, 16'h0, 0);      // FFFF wraps to 0000

    timeout_test();
    do_instr(1, 16'h8888, 0, 0, 8'h00, 0, 16'h0, 0);

    abort_fetch(1'b0);
    do_instr(0, 16'h9999, 0, 1, 8'h7F, 0, 16'h0, 0);
    abort_fetch(1'b1);
    do_instr(4, 16'hAAAA, 2, 0, 8'h00, 0, 16'h0, 1);

    do_reset(1'b1);
    @(negedge Clock);
    chk("idle_halt", {Halted, MemRead}, 2'b10);
    @(negedge Clock);
    chk("idle_halt_hold", {Halted, MemRead}, 2'b10);
    Halt = 1'b0;

    for (int k = 0; k < 40; k++) begin
      int unsigned kind;
      kind = $urandom_range(0, 3);
      do_instr(int'($urandom_range(0, MEM_TIMEOUT)), 16'($urandom),
               int'($urandom_range(0, 3)), kind == 1 || (kind == 0 && $urandom_range(0, 1) == 1),
               8'($urandom), kind == 0, 16'($urandom), $urandom_range(0, 7) == 0);
    end

    @(negedge Clock);
    chk("queues_drained", {32'(exp_instr_q.size()), 32'(exp_upd_q.size())}, 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
